// File: rtl/instr_pkg.sv
// instr_pkg: RV32 opcode constants and immediate format codes shared by the decoder queue.
package instr_pkg;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  typedef enum logic [2:0] {
    IMM_R, IMM_I, IMM_ISH, IMM_S, IMM_B, IMM_U, IMM_J, IMM_ILL
  } imm_type_e;
endpackage

// File: rtl/instr_queue_decoder_imm_gen.sv
// imm_gen: classifies an RV32 word into its immediate format and extends the immediate to XLEN.
// DECODE_ILLEGAL_EN flags unrecognised opcodes as illegal; otherwise they decode as R.
module imm_gen
  import instr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);
  logic [31:0] imm32;
  always_comb begin
    imm32 = '0;
    imm_type = IMM_R;
    illegal = 1'b0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        imm_type = IMM_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        imm_type = IMM_J;
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD: begin
        imm_type = IMM_I;
        imm32 = {{21{instr[31]}}, instr[30:20]};
      end
      OP_IMM: begin
        imm_type = instr[13:12] == 2'b01 ? IMM_ISH : IMM_I;
        imm32 = instr[13:12] == 2'b01
          ? ((XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]})
          : {{21{instr[31]}}, instr[30:20]};
      end
      OP_STORE: begin
        imm_type = IMM_S;
        imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      end
      OP_BRANCH: begin
        imm_type = IMM_B;
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_OP: imm_type = IMM_R;
      default: begin
`ifdef DECODE_ILLEGAL_EN
        imm_type = IMM_ILL;
        illegal = 1'b1;
`else
        imm_type = IMM_R;
`endif
      end
    endcase
  end
  // shamt has bit 31 clear, so signed extension leaves it zero-extended
  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/instr_queue_decoder.sv
// instr_queue_decoder: instruction FIFO whose head sits in a registered, pre-decoded output stage.
// DECODE_ILLEGAL_EN enables illegal-opcode detection in the immediate generator.
module instr_queue_decoder
  import instr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [6:0]                 OPC,
  output logic [6:0]                 func7,
  output logic [2:0]                 func3,
  output logic [4:0]                 RS1,
  output logic [4:0]                 RS2,
  output logic [4:0]                 RD,
  output logic [XLEN-1:0]            imm_out,
  output logic [2:0]                 imm_type,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] fc;
  logic push, pop, load, fpop, direct, fpush;
  logic [31:0] src;
  logic [XLEN-1:0] imm_n;
  logic [2:0] type_n;
  logic ill_n;
  assign in_ready = count < CW'(DEPTH);
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready;
  assign load = !out_valid || pop;
  assign fpop = load && fc != '0;
  // an empty queue bypasses storage so the first word appears after one edge
  assign direct = load && fc == '0 && push;
  assign fpush = push && !direct;
  assign src = fc != '0 ? mem[rd] : in_instr;
  imm_gen #(.XLEN(XLEN)) u_imm (.instr(src), .imm(imm_n), .imm_type(type_n), .illegal(ill_n));
  always_ff @(posedge clk)
    if (fpush) mem[wr] <= in_instr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      fc <= '0;
      count <= '0;
      out_valid <= 1'b0;
      OPC <= '0;
      func7 <= '0;
      func3 <= '0;
      RS1 <= '0;
      RS2 <= '0;
      RD <= '0;
      imm_out <= '0;
      imm_type <= '0;
      illegal <= 1'b0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      fc <= '0;
      count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fpush) wr <= wr + 1'b1;
      if (fpop) rd <= rd + 1'b1;
      fc <= fc + CW'(fpush) - CW'(fpop);
      count <= count + CW'(push) - CW'(pop);
      if (load) out_valid <= fpop || direct;
      if (fpop || direct) begin
        OPC <= src[6:0];
        RD <= src[11:7];
        func3 <= src[14:12];
        RS1 <= src[19:15];
        RS2 <= src[24:20];
        func7 <= src[31:25];
        imm_out <= imm_n;
        imm_type <= type_n;
        illegal <= ill_n;
      end
    end
endmodule

// File: tb/tb_instr_queue_decoder.sv
// tb_instr_queue_decoder: directed decode vectors plus backpressure, flush and async-reset sequences.
module tb_instr_queue_decoder;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0, in_ready, out_valid, illegal;
  logic [31:0] in_instr = '0, imm_out;
  logic [6:0] OPC, func7;
  logic [2:0] func3, imm_type, count;
  logic [4:0] RS1, RS2, RD;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } vec_t;
  vec_t tv[11];
  instr_queue_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .OPC(OPC), .func7(func7),
    .func3(func3), .RS1(RS1), .RS2(RS2), .RD(RD), .imm_out(imm_out), .imm_type(imm_type),
    .illegal(illegal), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_hold(input logic [31:0] w);
    in_valid = 1;
    in_instr = w;
    @(negedge clk);
    in_valid = 0;
  endtask
  initial begin
    tv[0]  = '{32'hFFF00093, 7'h13, 7'h7F, 3'd0, 5'd0, 5'd31, 5'd1,  32'hFFFFFFFF, 3'd1, 1'b0};
    tv[1]  = '{32'h0020A423, 7'h23, 7'h00, 3'd2, 5'd1, 5'd2,  5'd8,  32'h00000008, 3'd3, 1'b0};
    tv[2]  = '{32'hFE000EE3, 7'h63, 7'h7F, 3'd0, 5'd0, 5'd0,  5'd29, 32'hFFFFFFFC, 3'd4, 1'b0};
    tv[3]  = '{32'h123452B7, 7'h37, 7'h09, 3'd5, 5'd8, 5'd3,  5'd5,  32'h12345000, 3'd5, 1'b0};
    tv[4]  = '{32'h00309093, 7'h13, 7'h00, 3'd1, 5'd1, 5'd3,  5'd1,  32'h00000003, 3'd2, 1'b0};
    tv[5]  = '{32'h4030D093, 7'h13, 7'h20, 3'd5, 5'd1, 5'd3,  5'd1,  32'h00000003, 3'd2, 1'b0};
    tv[6]  = '{32'h008000EF, 7'h6F, 7'h00, 3'd0, 5'd0, 5'd8,  5'd1,  32'h00000008, 3'd6, 1'b0};
    tv[7]  = '{32'hFFC12083, 7'h03, 7'h7F, 3'd2, 5'd2, 5'd28, 5'd1,  32'hFFFFFFFC, 3'd1, 1'b0};
    tv[8]  = '{32'h002081B3, 7'h33, 7'h00, 3'd0, 5'd1, 5'd2,  5'd3,  32'h00000000, 3'd0, 1'b0};
    tv[9]  = '{32'h00001017, 7'h17, 7'h00, 3'd1, 5'd0, 5'd0,  5'd0,  32'h00001000, 3'd5, 1'b0};
`ifdef DECODE_ILLEGAL_EN
    tv[10] = '{32'h0000007F, 7'h7F, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0,  32'h00000000, 3'd7, 1'b1};
`else
    tv[10] = '{32'h0000007F, 7'h7F, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0};
`endif
    #1;
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset count", 64'(count), 0);
    chk("reset in_ready", 64'(in_ready), 1);
    chk("reset imm_out", 64'(imm_out), 0);
    chk("reset OPC", 64'(OPC), 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    foreach (tv[i]) begin
      push_hold(tv[i].instr);
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 1);
      chk($sformatf("v%0d count", i), 64'(count), 1);
      chk($sformatf("v%0d OPC", i), 64'(OPC), 64'(tv[i].opc));
      chk($sformatf("v%0d func7", i), 64'(func7), 64'(tv[i].f7));
      chk($sformatf("v%0d func3", i), 64'(func3), 64'(tv[i].f3));
      chk($sformatf("v%0d RS1", i), 64'(RS1), 64'(tv[i].rs1));
      chk($sformatf("v%0d RS2", i), 64'(RS2), 64'(tv[i].rs2));
      chk($sformatf("v%0d RD", i), 64'(RD), 64'(tv[i].rd));
      chk($sformatf("v%0d imm_out", i), 64'(imm_out), 64'(tv[i].imm));
      chk($sformatf("v%0d imm_type", i), 64'(imm_type), 64'(tv[i].typ));
      chk($sformatf("v%0d illegal", i), 64'(illegal), 64'(tv[i].ill));
      @(negedge clk);
      chk($sformatf("v%0d drained", i), 64'(out_valid), 0);
    end
    // backpressure: five offers into a four-entry queue, then drain in order
    out_ready = 0;
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_instr = k < 4 ? tv[k+1].instr : tv[8].instr;
      @(negedge clk);
      chk($sformatf("fill%0d count", k), 64'(count), 64'(k < 4 ? k + 1 : 4));
      chk($sformatf("fill%0d in_ready", k), 64'(in_ready), 64'(k < 3));
    end
    in_valid = 0;
    chk("full head stable", 64'(imm_out), 64'(tv[1].imm));
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d out_valid", k), 64'(out_valid), 1);
      chk($sformatf("drain%0d imm_out", k), 64'(imm_out), 64'(tv[k+1].imm));
      chk($sformatf("drain%0d imm_type", k), 64'(imm_type), 64'(tv[k+1].typ));
      chk($sformatf("drain%0d count", k), 64'(count), 64'(4 - k));
      @(negedge clk);
    end
    chk("drained out_valid", 64'(out_valid), 0);
    chk("drained count", 64'(count), 0);
    // simultaneous push and pop keeps count
    out_ready = 0;
    push_hold(tv[0].instr);
    push_hold(tv[9].instr);
    in_valid = 1;
    in_instr = tv[6].instr;
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    chk("push+pop count", 64'(count), 2);
    chk("push+pop head", 64'(imm_out), 64'(tv[9].imm));
    out_ready = 1;
    @(negedge clk);
    chk("push+pop order", 64'(imm_out), 64'(tv[6].imm));
    @(negedge clk);
    chk("push+pop empty", 64'(count), 0);
    // flush with a concurrent push drops everything
    out_ready = 0;
    push_hold(tv[1].instr);
    push_hold(tv[2].instr);
    push_hold(tv[3].instr);
    chk("pre-flush count", 64'(count), 3);
    in_valid = 1;
    in_instr = tv[7].instr;
    flush = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("flush count", 64'(count), 0);
    chk("flush out_valid", 64'(out_valid), 0);
    out_ready = 1;
    @(negedge clk);
    chk("flush no ghost", 64'(out_valid), 0);
    chk("flush in_ready", 64'(in_ready), 1);
    // asynchronous reset between edges while draining
    out_ready = 0;
    push_hold(tv[0].instr);
    push_hold(tv[3].instr);
    push_hold(tv[5].instr);
    out_ready = 1;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst out_valid", 64'(out_valid), 0);
    chk("arst OPC", 64'(OPC), 0);
    chk("arst RD", 64'(RD), 0);
    chk("arst imm_out", 64'(imm_out), 0);
    chk("arst imm_type", 64'(imm_type), 0);
    chk("arst count", 64'(count), 0);
    chk("arst in_ready", 64'(in_ready), 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    chk("post-arst out_valid", 64'(out_valid), 0);
    chk("post-arst count", 64'(count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
